// File: rtl/hades_pio_pkg.sv
// hades_pio_pkg
// Shared definitions for the input PIO:
//   - Avalon word addresses of the register map
//   - edge-type encodings for the EDGE_TYPE parameter
package hades_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/hades_sync_bus.sv
// hades_sync_bus
// WIDTH-wide multi-flop synchronizer for an asynchronous input bus.
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears every stage
//   d_i     : asynchronous input bus
//   q_o     : synchronized bus (last stage)
module hades_sync_bus #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= d_i;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_q[gi] <= '0;
                end else begin
                    stage_q[gi] <= stage_q[gi-1];
                end
            end
        end
    endgenerate

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/hades_pio_in.sv
// hades_pio_in
// Avalon-MM slave input PIO: synchronizes an external input bus, latches
// selected edges per bit into a sticky W1C capture register and raises a
// level interrupt when a captured edge is enabled by the mask.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      : Avalon-MM slave write/select inputs
//   readdata                : combinational read data, zero-extended
//   in_port                 : asynchronous external input bus
//   irq                     : registered level interrupt, active high
module hades_pio_in
    import hades_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Detection is enabled once the synchronizer and data_prev are both
    // filled with real samples, so an input already high at reset release
    // is not mistaken for an edge.
    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic [2:0]       warm_q;
    logic             warm_done;
    logic             irq_q;
    logic             wr_en;

    hades_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (data_in)
    );

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_raw = ~data_in & data_prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_raw = data_in ^ data_prev_q;
        end else begin : g_rise
            assign edge_raw = data_in & ~data_prev_q;
        end

        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
        end
    endgenerate

    assign warm_done = (warm_q == WARM_MAX);
    assign edge_det  = warm_done ? edge_raw : '0;
    assign wr_en     = chipselect & ~write_n;

    always_comb begin
        mask_d   = mask_q;
        clr_bits = '0;
        if (wr_en && address == ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGE) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        // A new edge on the same cycle as its clear keeps the bit set.
        cap_d = (cap_q & ~clr_bits) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_prev_q <= '0;
            mask_q      <= '0;
            cap_q       <= '0;
            warm_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            data_prev_q <= data_in;
            mask_q      <= mask_d;
            cap_q       <= cap_d;
            irq_q       <= |(cap_q & mask_q);
            if (!warm_done) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = data_in;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:   readdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_hades_pio_in.sv
module tb_hades_pio_in;

    localparam int SS = 2;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd [3];
    logic        irq_w [3];

    int n_checks;
    int n_fail;

    // Reference model: the sampled history of in_port since reset release,
    // plus per-instance capture/irq and the shared mask.
    logic [7:0] hist [$];
    logic [7:0] cap_m [3];
    logic       irq_m [3];
    logic [7:0] mask_m;

    hades_pio_in #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
        .in_port(in_port), .irq(irq_w[0]));

    hades_pio_in #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
        .in_port(in_port), .irq(irq_w[1]));

    hades_pio_in #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
        .in_port(in_port), .irq(irq_w[2]));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        mask_m = 8'h00;
        for (int t = 0; t < 3; t++) begin
            cap_m[t] = 8'h00;
            irq_m[t] = 1'b0;
        end
    endtask

    // Data visible after edge n is the input sampled SS-1 edges earlier.
    function automatic logic [31:0] exp_read(input int t, input logic [1:0] a);
        int n;
        n = hist.size();
        case (a)
            2'd0:    exp_read = (n >= SS) ? {24'h0, hist[n-SS]} : 32'h0;
            2'd2:    exp_read = {24'h0, mask_m};
            2'd3:    exp_read = {24'h0, cap_m[t]};
            default: exp_read = 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic [7:0] inp, input logic we,
                              input logic [1:0] a, input logic [31:0] wd);
        int n;
        logic [7:0] d, p, det, clr;
        hist.push_back(inp);
        n = hist.size();
        clr = (we && a == 2'd3) ? wd[7:0] : 8'h00;
        for (int t = 0; t < 3; t++) begin
            det = 8'h00;
            // Edges counted only once warm-up has passed (edge SS+2 onward).
            if (n >= SS + 2) begin
                d = hist[n-SS-1];
                p = hist[n-SS-2];
                case (t)
                    0:       det = d & ~p;
                    1:       det = ~d & p;
                    default: det = d ^ p;
                endcase
            end
            irq_m[t] = |(cap_m[t] & mask_m);
            cap_m[t] = (cap_m[t] & ~clr) | det;
        end
        if (we && a == 2'd2) mask_m = wd[7:0];
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            for (int t = 0; t < 3; t++)
                check_eq($sformatf("%s_rd%0d_t%0d", tag, a, t), rd[t], exp_read(t, 2'(a)));
        end
        for (int t = 0; t < 3; t++)
            check_eq($sformatf("%s_irq_t%0d", tag, t), {31'h0, irq_w[t]}, {31'h0, irq_m[t]});
    endtask

    // One clock transaction; called at a negedge, returns at the next negedge.
    task automatic cyc(input string tag, input logic [7:0] inp, input logic we,
                       input logic [1:0] a, input logic [31:0] wd);
        in_port    = inp;
        chipselect = we;
        write_n    = ~we;
        address    = a;
        writedata  = wd;
        if (we) $display("wr addr=%0d data=0x%08h in_port=0x%02h", a, wd, inp);
        @(posedge clk);
        #1;
        model_step(inp, we, a, wd);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [7:0] inp, input int n);
        for (int i = 0; i < n; i++) cyc(tag, inp, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic mid_reset(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        $display("reset asserted");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  cur_in;
        logic [31:0] wd;
        logic [1:0]  wa;
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Input high across reset release: no spurious capture.
        idle("warm", 8'hFF, 4);
        address = 2'd0; #1;
        check_eq("warm_data_ff", rd[0], 32'h0000_00FF);
        address = 2'd3; #1;
        check_eq("warm_cap_zero", rd[0], 32'h0);
        @(negedge clk);

        // Rising edges with mask off, then enable one bit.
        idle("low", 8'h00, 4);
        idle("rise05", 8'h05, 4);
        address = 2'd3; #1;
        check_eq("cap_05", rd[0], 32'h0000_0005);
        @(negedge clk);
        cyc("mask04", 8'h05, 1'b1, 2'd2, 32'hFFFF_FF04);
        idle("irqon", 8'h05, 1);
        check_eq("irq_after_mask", {31'h0, irq_w[0]}, 32'h1);

        // W1C.
        cyc("w1c04", 8'h05, 1'b1, 2'd3, 32'h0000_0004);
        idle("w1c04b", 8'h05, 1);
        check_eq("irq_after_clr", {31'h0, irq_w[0]}, 32'h0);
        cyc("w1c01", 8'h05, 1'b1, 2'd3, 32'h0000_0001);

        // Clear coinciding with a new bit-0 edge: set wins.
        idle("b0low", 8'h00, 4);
        cyc("b0rise", 8'h01, 1'b0, 2'd0, 32'h0);
        cyc("b0rise2", 8'h01, 1'b0, 2'd0, 32'h0);
        cyc("b0clr", 8'h01, 1'b1, 2'd3, 32'h0000_00FF);
        address = 2'd3; #1;
        check_eq("set_wins_b0", rd[0] & 32'h1, 32'h1);
        @(negedge clk);

        // Falling / any-edge instances.
        idle("ff", 8'hFF, 4);
        cyc("clrall", 8'hFF, 1'b1, 2'd3, 32'h0000_00FF);
        idle("f0", 8'hF0, 4);
        address = 2'd3; #1;
        check_eq("fall_cap_0f", rd[1], 32'h0000_000F);
        @(negedge clk);
        idle("ff2", 8'hFF, 4);
        cyc("maskff", 8'hFF, 1'b1, 2'd2, 32'h0000_00FF);
        idle("irqhi", 8'hFF, 2);
        check_eq("irq_any_high", {31'h0, irq_w[2]}, 32'h1);

        // Reset while irq is high, then data is still the live input.
        mid_reset("midrst");
        idle("post_rst", 8'h3C, 4);
        cyc("wr_data", 8'h3C, 1'b1, 2'd0, 32'h0000_00AA);
        cyc("wr_rsvd", 8'h3C, 1'b1, 2'd1, 32'h0000_00AA);
        address = 2'd0; #1;
        check_eq("data_after_wr", rd[0], 32'h0000_003C);
        @(negedge clk);

        // Randomized traffic with one reset in the middle.
        cur_in = 8'h3C;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) cur_in = 8'($urandom);
            if (i == 150) mid_reset("rnd_rst");
            if ($urandom_range(0, 3) == 0) begin
                wa = 2'($urandom_range(0, 3));
                wd = $urandom;
                cyc("rnd", cur_in, 1'b1, wa, wd);
            end else begin
                cyc("rnd", cur_in, 1'b0, 2'd0, 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
